exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: NUM_REGS, default 14, number of implemented registers; valid ids 0..NUM_REGS-1.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr  input  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; imm8 = instr[7:0].
REQ-007 instr_ready  output  1  sequencer can accept an instruction.
REQ-008 read1_id  output  4  register-block read port 1 select.
REQ-009 read1_value  input  8  register-block read port 1 data.
REQ-010 read2_id  output  4  register-block read port 2 select.
REQ-011 read2_value  input  8  register-block read port 2 data.
REQ-012 write_id  output  4  register-block write select.
REQ-013 write_value  output  8  register-block write data.
REQ-014 write_enable  output  1  commit write_value to write_id at the next rising edge.
REQ-015 busy  output  1  instruction in flight.
REQ-016 done  output  1  one-cycle retire pulse.
REQ-017 illegal  output  1  one-cycle pulse, coincident with done, for a rejected instruction.
REQ-018 flag_zero, flag_carry  output  1 each  registered ALU flags.

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC, WB; IDLE->READ on accept, READ->EXEC, EXEC->WB, WB->IDLE, one clock each.
REQ-020 Accept SHALL occur at a rising edge with state IDLE and instr_valid=1; instr_ready=1 only in IDLE (combinational from state).
REQ-021 instr SHALL be latched at accept; instr_valid while busy is ignored and instr changes after accept have no effect.
REQ-022 read1_id=rs1, read2_id=rs2 SHALL be driven in READ, EXEC and WB; 0 in IDLE.
REQ-023 Operands SHALL be sampled from read1_value/read2_value at the READ->EXEC edge; result latched at the EXEC->WB edge.
REQ-024 Opcodes: 0 NOP, 1 ADD a+b, 2 SUB a-b, 3 AND, 4 OR, 5 XOR, 6 LDI rd=imm8, 7 MOV rd=a, 8 SHL a<<1, 9 SHR a>>1 (logical); 10..15 illegal.
REQ-025 Arithmetic SHALL be 8-bit modulo 256; ADD carry = bit 8 of the 9-bit sum; SUB carry = borrow (1 when a<b); SHL carry = a[7]; SHR carry = a[0]; AND/OR/XOR carry = 0.
REQ-026 flag_zero = (result==0); both flags update at the EXEC->WB edge for opcodes 1..5, 8, 9 only; held otherwise.
REQ-027 In WB, for opcodes 1..9 with rd<NUM_REGS: write_enable=1, write_id=rd, write_value=result; otherwise write_enable=0.
REQ-028 write_id and write_value SHALL be 0 whenever write_enable=0.
REQ-029 Latency: write_enable high exactly one cycle, between the 2nd and 3rd rising edges after the accepting edge; write commits at the 3rd.
REQ-030 done SHALL be 1 for exactly the WB cycle of every accepted instruction, including NOP and illegal.
REQ-031 illegal SHALL be 1 in WB for opcodes 10..15 or for a writing opcode with rd>=NUM_REGS; no write and no flag update then.
REQ-032 busy SHALL be 1 in READ, EXEC, WB.
REQ-033 Back-to-back: an instruction presented in the IDLE cycle following WB SHALL be accepted; throughput one instruction per 4 cycles.

Reset
REQ-034 reset_n=0 SHALL force IDLE immediately, asynchronously, at any state, discarding the in-flight instruction with no write.
REQ-035 Reset values: all outputs 0 except instr_ready=1; flags 0; latched instr/result 0.
REQ-036 After reset_n rises, acceptance SHALL begin at the first rising edge with instr_valid=1.

Verification
REQ-037 Reset, then idle -> instr_ready=1; all other outputs 0; no write_enable over 10 cycles.
REQ-038 instr=0x1234, read1_value=0x7F, read2_value=0x01 -> read ids 3/4; write_enable, write_id=2, write_value=0x80 in cycle 3 after accept; carry=0, zero=0, done=1.
REQ-039 instr=0x2101, a=0x05, b=0x07 -> write_id=1, write_value=0xFE, carry=1; then ADD 0xFF+0x01 -> write_value=0x00, zero=1, carry=1.
REQ-040 instr=0x65A5 -> write_id=5, write_value=0xA5; flags unchanged from the prior instruction.
REQ-041 instr=0xF000 and instr=0x1E12 -> write_enable never 1; illegal=1 and done=1 for one cycle each; flags unchanged.
REQ-042 Assert reset_n=0 mid-cycle during EXEC -> state IDLE and outputs at reset values immediately, no write_enable; instr_valid held high during busy -> no second accept until IDLE.

Source files
------------

// File: rtl/exec_sequencer.sv
// Four-phase instruction sequencer: IDLE -> READ -> EXEC -> WB, one clock each.
// It drives an external register block through two read ports and one write port.
module exec_sequencer #(
    parameter int NUM_REGS = 14
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  read1_id,
    input  logic [7:0]  read1_value,
    output logic [3:0]  read2_id,
    input  logic [7:0]  read2_value,
    output logic [3:0]  write_id,
    output logic [7:0]  write_value,
    output logic        write_enable,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        flag_zero,
    output logic        flag_carry
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    state_t      state, state_next;
    logic [15:0] instr_q;
    logic [7:0]  op_a, op_b;
    logic [7:0]  result_q;
    logic [7:0]  alu_result;
    logic        alu_carry;

    logic [3:0]  opcode, rd, rs1, rs2;
    logic        writes_op, rd_ok, commit, flag_op, illegal_op;

    assign opcode = instr_q[15:12];
    assign rd     = instr_q[11:8];
    assign rs1    = instr_q[7:4];
    assign rs2    = instr_q[3:0];

    assign writes_op  = (opcode >= 4'd1) && (opcode <= 4'd9);
    assign rd_ok      = ({1'b0, rd} < NUM_REGS_W);
    assign commit     = writes_op && rd_ok;
    // LDI and MOV write a register but leave the flags alone.
    assign flag_op    = commit && (opcode != 4'd6) && (opcode != 4'd7);
    assign illegal_op = (opcode >= 4'd10) || (writes_op && !rd_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result_q   <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ST_READ) begin
                op_a <= read1_value;
                op_b <= read2_value;
            end
            if (state == ST_EXEC) begin
                result_q <= alu_result;
                if (flag_op) begin
                    flag_zero  <= (alu_result == 8'h00);
                    flag_carry <= alu_carry;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        unique case (opcode)
            4'd1: {alu_carry, alu_result} = {1'b0, op_a} + {1'b0, op_b};
            // Bit 8 of the 9-bit difference is the borrow (a < b).
            4'd2: {alu_carry, alu_result} = {1'b0, op_a} - {1'b0, op_b};
            4'd3: alu_result = op_a & op_b;
            4'd4: alu_result = op_a | op_b;
            4'd5: alu_result = op_a ^ op_b;
            4'd6: alu_result = instr_q[7:0];
            4'd7: alu_result = op_a;
            4'd8: {alu_carry, alu_result} = {op_a, 1'b0};
            4'd9: {alu_result, alu_carry} = {1'b0, op_a};
            default: begin
                alu_result = 8'h00;
                alu_carry  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next   = state;
        instr_ready  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        read1_id     = 4'd0;
        read2_id     = 4'd0;
        write_enable = 1'b0;
        write_id     = 4'd0;
        write_value  = 8'h00;
        unique case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                busy       = 1'b1;
                read1_id   = rs1;
                read2_id   = rs2;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy       = 1'b1;
                read1_id   = rs1;
                read2_id   = rs2;
                state_next = ST_WB;
            end
            ST_WB: begin
                busy         = 1'b1;
                done         = 1'b1;
                illegal      = illegal_op;
                read1_id     = rs1;
                read2_id     = rs2;
                write_enable = commit;
                write_id     = commit ? rd : 4'd0;
                write_value  = commit ? result_q : 8'h00;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed steps push expected retire results,
// a negedge monitor pops and compares them when done pulses.
module tb_exec_sequencer;

    localparam int NUM_REGS = 14;

    logic        clock;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  read1_id, read2_id, write_id;
    logic [7:0]  read1_value, read2_value, write_value;
    logic        write_enable, busy, done, illegal, flag_zero, flag_carry;

    typedef struct {
        logic       we;
        logic [3:0] id;
        logic [7:0] val;
        logic       ill;
        logic       z;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   cyc;
    int   checks;
    int   errors;
    logic model_zero, model_carry;

    exec_sequencer #(.NUM_REGS(NUM_REGS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .read1_id    (read1_id),
        .read1_value (read1_value),
        .read2_id    (read2_id),
        .read2_value (read2_value),
        .write_id    (write_id),
        .write_value (write_value),
        .write_enable(write_enable),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from the instruction-set description.
    task automatic push_model(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   op, rdi, r, ai, bi;
        bit   c, wr;
        op  = int'(ins[15:12]);
        rdi = int'(ins[11:8]);
        ai  = int'(a);
        bi  = int'(b);
        r   = 0;
        c   = 0;
        case (op)
            1: begin r = (ai + bi) % 256; c = (ai + bi) > 255; end
            2: begin r = (ai - bi + 256) % 256; c = ai < bi; end
            3: r = int'(a & b);
            4: r = int'(a | b);
            5: r = int'(a ^ b);
            6: r = int'(ins[7:0]);
            7: r = ai;
            8: begin r = (ai * 2) % 256; c = ai >= 128; end
            9: begin r = ai / 2; c = (ai % 2) == 1; end
            default: r = 0;
        endcase
        wr    = (op >= 1) && (op <= 9);
        e.ill = (op >= 10) || (wr && rdi >= NUM_REGS);
        e.we  = wr && !e.ill;
        e.id  = e.we ? 4'(rdi) : 4'd0;
        e.val = e.we ? 8'(r) : 8'h00;
        if (e.we && op != 6 && op != 7) begin
            model_zero  = (r == 0);
            model_carry = c;
        end
        e.z = model_zero;
        e.c = model_carry;
        sb_q.push_back(e);
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            check("we_implies_done", {15'd0, write_enable & ~done}, 16'd0);
            if (!write_enable) begin
                check("idle_write_bus", {4'd0, write_id, write_value}, 16'd0);
            end
            if (done) begin
                check("sb_nonempty", {15'd0, sb_q.size() > 0}, 16'd1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("write_enable", {15'd0, write_enable}, {15'd0, e.we});
                    check("write_id", {12'd0, write_id}, {12'd0, e.id});
                    check("write_value", {8'd0, write_value}, {8'd0, e.val});
                    check("illegal", {15'd0, illegal}, {15'd0, e.ill});
                    check("flag_zero", {15'd0, flag_zero}, {15'd0, e.z});
                    check("flag_carry", {15'd0, flag_carry}, {15'd0, e.c});
                    if (acc_q.size() > 0) begin
                        check("retire_latency", 16'(cyc - acc_q.pop_front()), 16'd3);
                    end
                end
            end else begin
                check("illegal_without_done", {15'd0, illegal}, 16'd0);
            end
            if (instr_ready && instr_valid) begin
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !instr_ready; i++) begin
            @(posedge clock);
            #1;
        end
        check("ready_timeout", {15'd0, instr_ready}, 16'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("drain_timeout", 16'(sb_q.size()), 16'd0);
    endtask

    // One instruction; inputs change after acceptance to prove they were latched.
    task automatic run_instr(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] b);
        wait_ready();
        instr_valid = 1'b1;
        instr       = ins;
        read1_value = a;
        read2_value = b;
        push_model(ins, a, b);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        check("read1_id", {12'd0, read1_id}, {12'd0, ins[7:4]});
        check("read2_id", {12'd0, read2_id}, {12'd0, ins[3:0]});
        check("busy_ready", {14'd0, busy, instr_ready}, 16'b10);
        @(posedge clock);
        #1;
        read1_value = ~a;
        read2_value = ~b;
        check("read1_id_exec", {12'd0, read1_id}, {12'd0, ins[7:4]});
        drain();
    endtask

    initial begin
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        model_zero  = 1'b0;
        model_carry = 1'b0;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        read1_value = 8'h00;
        read2_value = 8'h00;

        #2;
        check("reset_outputs", {busy, done, illegal, write_enable, flag_zero, flag_carry,
                                instr_ready, read1_id, read2_id, 1'b0},
              16'b0000001_0000_0000_0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("idle_outputs", {10'd0, instr_ready, busy, done, write_enable,
                                   flag_zero, flag_carry}, 16'b100000);
        end

        run_instr(16'h1234, 8'h7F, 8'h01);
        run_instr(16'h2101, 8'h05, 8'h07);
        run_instr(16'h1312, 8'hFF, 8'h01);
        run_instr(16'h65A5, 8'h00, 8'h00);
        run_instr(16'hF000, 8'h11, 8'h22);
        run_instr(16'h1E12, 8'h33, 8'h44);
        run_instr(16'h3DAB, 8'hF0, 8'h3C);
        run_instr(16'h4812, 8'h0F, 8'hF0);
        run_instr(16'h5C45, 8'hAA, 8'hAA);
        run_instr(16'h7734, 8'h5A, 8'h00);
        run_instr(16'h8090, 8'h81, 8'h00);
        run_instr(16'h9B90, 8'h03, 8'h00);
        run_instr(16'h0923, 8'h01, 8'h02);
        run_instr(16'h2F12, 8'h01, 8'h02);
        for (int i = 0; i < 8; i++) begin
            run_instr(16'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)));
        end

        // Valid held through busy: exactly one accept per four cycles.
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'h4623;
        read1_value = 8'h0F;
        read2_value = 8'hF0;
        push_model(16'h4623, 8'h0F, 8'hF0);
        push_model(16'h4623, 8'h0F, 8'hF0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            check("b2b_ready", {15'd0, instr_ready}, {15'd0, k == 4});
        end
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        drain();

        // Make the flags non-zero so the reset really clears them.
        run_instr(16'h1312, 8'hFF, 8'h01);
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'h1123;
        read1_value = 8'h01;
        read2_value = 8'h01;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midexec_reset", {busy, done, illegal, write_enable, flag_zero, flag_carry,
                                instr_ready, read1_id, read2_id, 1'b0},
              16'b0000001_0000_0000_0);
        acc_q.delete();
        model_zero  = 1'b0;
        model_carry = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("post_reset_idle", {13'd0, instr_ready, busy, write_enable}, 16'b100);
        end
        run_instr(16'h6BC3, 8'h00, 8'h00);

        check("sb_empty_at_end", 16'(sb_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
